// File: rtl/ifid_pkg.sv
// Shared constants for the IF/ID fetch queue: default geometry and the bubble NOP word.
package ifid_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 32;
    localparam int DEF_DEPTH = 4;

    // All-zero word presented to decode as a bubble when the queue is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Pointer width for a power-of-two entry count
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifid_entry_ram.sv
// DEPTH x WIDTH entry storage: one write port, one asynchronous read port, cleared by reset.
module ifid_entry_ram
    import ifid_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_AW + DEF_DW,
    parameter int PTR_W = ptr_width(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] slot_we;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
        assign slot_we[gi] = we && (waddr == PTR_W'(gi));
    end

    // Storage must read back as zero after reset, so every slot is reset explicitly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ifid_fetch_queue.sv
// IF/ID decoupling FIFO of {PC+4, instruction} pairs with flush and stall handling.
// Optional macro IFID_BUBBLE_NOP_EN forces a NOP/zero PC on the outputs while empty.
module ifid_fetch_queue
    import ifid_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic [AW-1:0]              FROMIFPC4,
    input  logic [DW-1:0]              FROMORDER,
    input  logic                       IFVALID,
    output logic                       IFREADY,
    input  logic                       IFIDWRITE,
    input  logic                       IFFLASH,
    output logic [AW-1:0]              TOADD,
    output logic [DW-1:0]              TOMAINORDER,
    output logic                       IDVALID,
    output logic [$clog2(DEPTH):0]     QCOUNT
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head_reg,  head_next;
    logic [PTR_W-1:0] tail_reg,  tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             push;
    logic             pop;
    logic [AW+DW-1:0] head_word;

    assign IFREADY = (count_reg < CNT_W'(DEPTH));
    assign IDVALID = (count_reg != '0);
    assign QCOUNT  = count_reg;
    assign push    = IFVALID && IFREADY;
    assign pop     = IDVALID && IFIDWRITE;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (IFFLASH) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + PTR_W'(1);
            if (pop)  head_next = head_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // A push coinciding with a flush is discarded, so the write is suppressed too
    ifid_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW),
        .PTR_W (PTR_W)
    ) u_entry_ram (
        .clk   (CLOCK),
        .rst_n (RESET),
        .we    (push && !IFFLASH),
        .waddr (tail_reg),
        .wdata ({FROMIFPC4, FROMORDER}),
        .raddr (head_reg),
        .rdata (head_word)
    );

`ifdef IFID_BUBBLE_NOP_EN
    assign TOADD       = IDVALID ? head_word[AW+DW-1:DW] : '0;
    assign TOMAINORDER = IDVALID ? head_word[DW-1:0]     : DW'(NOP_INSTR);
`else
    // Empty queue shows the (possibly stale) head slot; decode qualifies with IDVALID
    assign TOADD       = head_word[AW+DW-1:DW];
    assign TOMAINORDER = head_word[DW-1:0];
`endif

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed self-checking bench for ifid_fetch_queue (DW=32, AW=32, DEPTH=4).
module tb_ifid_fetch_queue;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] FROMIFPC4 = '0;
    logic [31:0] FROMORDER = '0;
    logic        IFVALID = 1'b0;
    logic        IFREADY;
    logic        IFIDWRITE = 1'b0;
    logic        IFFLASH = 1'b0;
    logic [31:0] TOADD;
    logic [31:0] TOMAINORDER;
    logic        IDVALID;
    logic [2:0]  QCOUNT;

    int checks = 0;
    int errors = 0;

    ifid_fetch_queue #(.DW(32), .AW(32), .DEPTH(4)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .FROMIFPC4   (FROMIFPC4),
        .FROMORDER   (FROMORDER),
        .IFVALID     (IFVALID),
        .IFREADY     (IFREADY),
        .IFIDWRITE   (IFIDWRITE),
        .IFFLASH     (IFFLASH),
        .TOADD       (TOADD),
        .TOMAINORDER (TOMAINORDER),
        .IDVALID     (IDVALID),
        .QCOUNT      (QCOUNT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there after the rising edge
    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc4);
        return 32'hA000_0000 | pc4;
    endfunction

    task automatic drive_push(input logic [31:0] pc4);
        IFVALID   = 1'b1;
        FROMIFPC4 = pc4;
        FROMORDER = instr_of(pc4);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(IFREADY), 64'd1);
        check({tag, "_idvalid"}, 64'(IDVALID), 64'd0);
        check({tag, "_toadd"}, 64'(TOADD), 64'd0);
        check({tag, "_instr"}, 64'(TOMAINORDER), 64'd0);
        check({tag, "_qcount"}, 64'(QCOUNT), 64'd0);
    endtask

    initial begin
        // Reset held from time zero
        #3;
        check_reset_state("rst");
        @(negedge CLOCK);
        RESET = 1'b1;
        step();
        check_reset_state("post_rst");

        // First push appears on the ID outputs right after its edge
        IFVALID = 1'b1; FROMIFPC4 = 32'h4; FROMORDER = 32'h2008_0001;
        step();
        IFVALID = 1'b0;
        check("first_idvalid", 64'(IDVALID), 64'd1);
        check("first_toadd", 64'(TOADD), 64'h4);
        check("first_instr", 64'(TOMAINORDER), 64'h2008_0001);
        check("first_qcount", 64'(QCOUNT), 64'd1);

        // Drain, then fill to DEPTH with decode stalled
        IFIDWRITE = 1'b1;
        step();
        IFIDWRITE = 1'b0;
        check("drain_qcount", 64'(QCOUNT), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            drive_push(32'(4 * k));
            step();
        end
        check("full_qcount", 64'(QCOUNT), 64'd4);
        check("full_ready", 64'(IFREADY), 64'd0);
        drive_push(32'h14);
        step();
        IFVALID = 1'b0;
        check("overflow_qcount", 64'(QCOUNT), 64'd4);
        IFIDWRITE = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("pop_order%0d", k), 64'(TOADD), 64'(32'(4 * k)));
            check($sformatf("pop_instr%0d", k), 64'(TOMAINORDER), 64'(instr_of(32'(4 * k))));
            step();
        end
        IFIDWRITE = 1'b0;
        check("empty_idvalid", 64'(IDVALID), 64'd0);
        check("empty_ready", 64'(IFREADY), 64'd1);
`ifdef IFID_BUBBLE_NOP_EN
        check("empty_toadd", 64'(TOADD), 64'h0);
        check("empty_instr", 64'(TOMAINORDER), 64'h0);
`else
        // Head is back at slot 1, which still holds PC4=0x4
        check("stale_toadd", 64'(TOADD), 64'h4);
`endif

        // Two entries, then six cycles of simultaneous push and pop
        drive_push(32'h20); step();
        drive_push(32'h24); step();
        check("two_qcount", 64'(QCOUNT), 64'd2);
        IFIDWRITE = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_push(32'(32'h28 + 4 * k));
            check($sformatf("pp_head%0d", k), 64'(TOADD), 64'(32'(32'h20 + 4 * k)));
            step();
            check($sformatf("pp_qcount%0d", k), 64'(QCOUNT), 64'd2);
        end
        IFIDWRITE = 1'b0;
        IFVALID   = 1'b0;
        check("pp_final_head", 64'(TOADD), 64'h38);
        check("pp_final_instr", 64'(TOMAINORDER), 64'(instr_of(32'h38)));

        // Flush with three entries and a concurrent push and pop
        drive_push(32'h40); step();
        check("pre_flush_qcount", 64'(QCOUNT), 64'd3);
        drive_push(32'h44);
        IFIDWRITE = 1'b1;
        IFFLASH   = 1'b1;
        step();
        IFFLASH   = 1'b0;
        IFIDWRITE = 1'b0;
        IFVALID   = 1'b0;
        check("flush_qcount", 64'(QCOUNT), 64'd0);
        check("flush_idvalid", 64'(IDVALID), 64'd0);
        check("flush_ready", 64'(IFREADY), 64'd1);
`ifdef IFID_BUBBLE_NOP_EN
        check("flush_instr", 64'(TOMAINORDER), 64'h0);
        check("flush_toadd", 64'(TOADD), 64'h0);
`else
        // Head reset to slot 0, whose last write was PC4=0x3C
        check("flush_stale_toadd", 64'(TOADD), 64'h3C);
        check("flush_stale_instr", 64'(TOMAINORDER), 64'(instr_of(32'h3C)));
`endif
        drive_push(32'h50); step();
        IFVALID = 1'b0;
        check("post_flush_toadd", 64'(TOADD), 64'h50);
        check("post_flush_qcount", 64'(QCOUNT), 64'd1);

        // Pop requests on an empty queue are ignored
        IFIDWRITE = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("underflow_qcount%0d", k), 64'(QCOUNT), 64'd0);
            check($sformatf("underflow_idvalid%0d", k), 64'(IDVALID), 64'd0);
        end
        IFIDWRITE = 1'b0;
        drive_push(32'h60); step();
        check("after_underflow_toadd", 64'(TOADD), 64'h60);
        check("after_underflow_qcount", 64'(QCOUNT), 64'd1);

        // Asynchronous reset between edges with two entries held
        drive_push(32'h64); step();
        IFVALID = 1'b0;
        check("pre_async_qcount", 64'(QCOUNT), 64'd2);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge CLOCK);
        check_reset_state("async_rst_hold");
        RESET = 1'b1;
        drive_push(32'h70); step();
        IFVALID = 1'b0;
        check("post_async_toadd", 64'(TOADD), 64'h70);
        check("post_async_instr", 64'(TOMAINORDER), 64'(instr_of(32'h70)));
        check("post_async_qcount", 64'(QCOUNT), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
